add_cal_mch_mod: RTL

- Multi-channel accumulating statistics counter; parametrised successor of the single-channel split-carry adder.
- Holds CH_NUM independent ADD_OT_WIDTH-bit counters. Each counter is built as a low half and a high half joined by a registered carry.
- Adds wrap/saturate mode, a per-channel overflow flag, a per-channel read port with optional read-clear, and a global clear.
- Sits between packet/byte event sources and the CPU register bank.

---
 rtl/add_cal_mch_mod_if.sv | 28 ++
 rtl/add_cal_mch_mod.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/add_cal_mch_mod_if.sv
// Increment/read port bundle for the multi-channel accumulating counter.
// The master side drives increments and reads; the slave side returns read data.
interface add_cal_mch_mod_if #(
    parameter int unsigned CH_W         = 3,
    parameter int unsigned ADD_IN_WIDTH = 8,
    parameter int unsigned ADD_OT_WIDTH = 64
);
    logic                    clr_en;
    logic [ADD_IN_WIDTH-1:0] data_in;
    logic [CH_W-1:0]         data_in_ch;
    logic                    data_in_en;
    logic                    rd_req;
    logic [CH_W-1:0]         rd_ch;
    logic                    rd_clr;
    logic                    rd_vld;
    logic [ADD_OT_WIDTH-1:0] rd_data;
    logic                    rd_ovf;

    modport master (
        output clr_en, data_in, data_in_ch, data_in_en, rd_req, rd_ch, rd_clr,
        input  rd_vld, rd_data, rd_ovf
    );

    modport slave (
        input  clr_en, data_in, data_in_ch, data_in_en, rd_req, rd_ch, rd_clr,
        output rd_vld, rd_data, rd_ovf
    );
endinterface

// File: rtl/add_cal_mch_mod.sv
// Multi-channel statistics counter: each channel is a low/high split adder joined by a
// registered carry, with wrap or saturate mode, sticky overflow and read/read-clear port.
module add_cal_mch_mod #(
    parameter int unsigned CH_NUM       = 8,
    parameter int unsigned CH_W         = $clog2(CH_NUM),
    parameter int unsigned ADD_IN_WIDTH = 8,
    parameter int unsigned ADD_OT_WIDTH = 64,
    parameter int unsigned ADD_TP_WIDTH = ADD_OT_WIDTH / 2,
    parameter bit          SAT_EN       = 1'b0
) (
    input logic              clk,
    input logic              rst,
    add_cal_mch_mod_if.slave bus
);
    localparam int unsigned HI_W  = ADD_OT_WIDTH - ADD_TP_WIDTH;
    localparam int unsigned LO_SW = ADD_TP_WIDTH + 1;
    localparam int unsigned HI_SW = HI_W + 1;

    typedef logic [ADD_TP_WIDTH-1:0] lo_t;
    typedef logic [HI_W-1:0]         hi_t;

    lo_t               lo_q [CH_NUM];
    lo_t               lo_d [CH_NUM];
    hi_t               hi_q [CH_NUM];
    hi_t               hi_d [CH_NUM];
    logic [CH_NUM-1:0] ovf_q;
    logic [CH_NUM-1:0] ovf_d;

    logic                    s0_vld_q;
    logic [CH_W-1:0]         s0_ch_q;
    logic [ADD_IN_WIDTH-1:0] s0_data_q;
    logic                    s1_cy_q;
    logic                    s1_cy_d;
    logic [CH_W-1:0]         s1_ch_q;

    logic                    r0_vld_q;
    logic                    r0_clr_q;
    logic                    r0_zero_q;
    logic [CH_W-1:0]         r0_ch_q;
    logic                    r1_vld_q;
    logic                    r1_clr_q;
    logic                    r1_zero_q;
    logic [CH_W-1:0]         r1_ch_q;
    lo_t                     r1_lo_q;
    logic                    r2_vld_q;
    logic                    r2_zero_q;
    logic                    r2_ovf_q;
    lo_t                     r2_lo_q;
    hi_t                     r2_hi_q;
    logic                    rd_vld_q;
    logic                    rd_ovf_q;
    logic [ADD_OT_WIDTH-1:0] rd_data_q;

    logic             inc_ok;
    logic             rd_ok;
    lo_t              r0_lo_sel;
    hi_t              r1_hi_sel;
    logic             r1_ovf_sel;
    lo_t              lo_base;
    hi_t              hi_base;
    logic             hi_clr;
    logic [LO_SW-1:0] lo_sum;
    logic [HI_SW-1:0] hi_sum;

    assign inc_ok = 32'(bus.data_in_ch) < CH_NUM;
    assign rd_ok  = 32'(bus.rd_ch) < CH_NUM;

    // A read-clear zeroes the low half one edge after the request and the high half/flag
    // one edge later, exactly where that request's snapshot of each half is taken, so the
    // snapshot keeps older increments while newer ones land on the cleared base.
    always_comb begin
        s1_cy_d    = 1'b0;
        r0_lo_sel  = '0;
        r1_hi_sel  = '0;
        r1_ovf_sel = 1'b0;
        lo_base    = '0;
        hi_base    = '0;
        hi_clr     = 1'b0;
        lo_sum     = '0;
        hi_sum     = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            lo_base = (r0_clr_q && (r0_ch_q == CH_W'(i))) ? '0 : lo_q[i];
            lo_sum  = {1'b0, lo_base};
            if (s0_vld_q && (s0_ch_q == CH_W'(i))) begin
                lo_sum  = {1'b0, lo_base} + LO_SW'(s0_data_q);
                s1_cy_d = lo_sum[ADD_TP_WIDTH];
            end
            lo_d[i] = lo_sum[ADD_TP_WIDTH-1:0];

            hi_clr   = r1_clr_q && (r1_ch_q == CH_W'(i));
            hi_base  = hi_clr ? '0 : hi_q[i];
            hi_sum   = {1'b0, hi_base} + HI_SW'(s1_cy_q && (s1_ch_q == CH_W'(i)));
            hi_d[i]  = hi_sum[HI_W-1:0];
            ovf_d[i] = (ovf_q[i] & ~hi_clr) | hi_sum[HI_W];

            if (r0_ch_q == CH_W'(i)) begin
                r0_lo_sel = lo_q[i];
            end
            if (r1_ch_q == CH_W'(i)) begin
                r1_hi_sel  = hi_q[i];
                r1_ovf_sel = ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q      <= '{default: '0};
            hi_q      <= '{default: '0};
            ovf_q     <= '0;
            s0_vld_q  <= 1'b0;
            s0_ch_q   <= '0;
            s0_data_q <= '0;
            s1_cy_q   <= 1'b0;
            s1_ch_q   <= '0;
        end else if (bus.clr_en) begin
            lo_q     <= '{default: '0};
            hi_q     <= '{default: '0};
            ovf_q    <= '0;
            s0_vld_q <= 1'b0;
            s1_cy_q  <= 1'b0;
        end else begin
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            ovf_q     <= ovf_d;
            s0_vld_q  <= bus.data_in_en && inc_ok;
            s0_ch_q   <= bus.data_in_ch;
            s0_data_q <= bus.data_in;
            s1_cy_q   <= s1_cy_d;
            s1_ch_q   <= s0_ch_q;
        end
    end

    // Once saturated the halves keep wrapping internally; the sticky flag alone
    // stands for all-ones until the channel is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_vld_q  <= 1'b0;
            r0_clr_q  <= 1'b0;
            r0_zero_q <= 1'b0;
            r0_ch_q   <= '0;
            r1_vld_q  <= 1'b0;
            r1_clr_q  <= 1'b0;
            r1_zero_q <= 1'b0;
            r1_ch_q   <= '0;
            r1_lo_q   <= '0;
            r2_vld_q  <= 1'b0;
            r2_zero_q <= 1'b0;
            r2_ovf_q  <= 1'b0;
            r2_lo_q   <= '0;
            r2_hi_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_ovf_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            r0_vld_q  <= bus.rd_req;
            r0_ch_q   <= bus.rd_ch;
            r0_clr_q  <= bus.rd_req && bus.rd_clr && rd_ok && !bus.clr_en;
            r0_zero_q <= !rd_ok || bus.clr_en;
            r1_vld_q  <= r0_vld_q;
            r1_ch_q   <= r0_ch_q;
            r1_clr_q  <= r0_clr_q;
            r1_zero_q <= r0_zero_q || bus.clr_en;
            r1_lo_q   <= r0_lo_sel;
            r2_vld_q  <= r1_vld_q;
            r2_zero_q <= r1_zero_q || bus.clr_en;
            r2_lo_q   <= r1_lo_q;
            r2_hi_q   <= r1_hi_sel;
            r2_ovf_q  <= r1_ovf_sel;
            rd_vld_q  <= r2_vld_q;
            if (r2_vld_q) begin
                if (r2_zero_q || bus.clr_en) begin
                    rd_data_q <= '0;
                    rd_ovf_q  <= 1'b0;
                end else if (SAT_EN && r2_ovf_q) begin
                    rd_data_q <= '1;
                    rd_ovf_q  <= 1'b1;
                end else begin
                    rd_data_q <= {r2_hi_q, r2_lo_q};
                    rd_ovf_q  <= r2_ovf_q;
                end
            end
        end
    end

    assign bus.rd_vld  = rd_vld_q;
    assign bus.rd_data = rd_data_q;
    assign bus.rd_ovf  = rd_ovf_q;
endmodule
